// File: rtl/aes_hmac_frame_collector_if.sv
// Stream and result bundle between the AES/HMAC byte stream and the frame
// collector.
//   master : drives the byte stream, the tag check enable and the expected tag;
//            observes the rebuilt frame and the status pulses.
//   slave  : the collector. It consumes the stream and produces o_cipher,
//            o_tag, o_done, o_tag_ok, o_err, o_err_code and o_busy.
interface aes_hmac_frame_collector_if #(
    parameter int BURST_BYTES = 16
);
    localparam int W = 8 * BURST_BYTES;

    logic [7:0]   i_data;
    logic         i_valid;
    logic         i_check_en;
    logic [W-1:0] i_exp_tag;

    logic [W-1:0] o_cipher;
    logic [W-1:0] o_tag;
    logic         o_done;
    logic         o_tag_ok;
    logic         o_err;
    logic [1:0]   o_err_code;
    logic         o_busy;

    modport master (
        output i_data, i_valid, i_check_en, i_exp_tag,
        input  o_cipher, o_tag, o_done, o_tag_ok, o_err, o_err_code, o_busy
    );

    modport slave (
        input  i_data, i_valid, i_check_en, i_exp_tag,
        output o_cipher, o_tag, o_done, o_tag_ok, o_err, o_err_code, o_busy
    );
endinterface

// File: rtl/aes_hmac_frame_collector.sv
// Rebuilds one frame from the AES/HMAC byte stream. A frame is a 16-byte
// ciphertext burst, an optional idle gap, then a 16-byte tag burst.
// Both words are presented in parallel. The tag can optionally be compared
// with an expected value. Malformed streams are reported and then discarded.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   bus.slave  : i_data/i_valid stream in, i_check_en/i_exp_tag tag check;
//                o_cipher/o_tag/o_tag_ok (updated with the o_done pulse),
//                o_err pulse with o_err_code (1 short, 2 gap timeout,
//                3 overrun), o_busy (any state except IDLE)
module aes_hmac_frame_collector #(
    parameter int BURST_BYTES = 16,
    parameter int GAP_TIMEOUT = 4096
) (
    input  logic                             clk,
    input  logic                             rst_n,
    aes_hmac_frame_collector_if.slave        bus
);
    localparam int              GW       = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
    localparam logic [GW-1:0]   GAP_LAST = GW'(GAP_TIMEOUT - 1);
    localparam logic [4:0]      LAST     = 5'(BURST_BYTES - 1);

    typedef enum logic [2:0] {IDLE, CIPHER, GAP, TAG, DONE} state_t;

    state_t                        state;
    logic [4:0]                    cnt;
    logic [GW-1:0]                 gap_cnt;
    logic                          wait_low;   // after an overrun, ignore the stream until i_valid drops
    logic [BURST_BYTES-1:0][7:0]   cipher_sh;
    logic [BURST_BYTES-1:0][7:0]   tag_sh;
    logic [BURST_BYTES-1:0][7:0]   tag_full;

    // Build the tag word including the byte arriving this cycle. The result
    // and the compare can then be registered on the same edge as the last byte.
    always_comb begin
        tag_full                = tag_sh;
        tag_full[BURST_BYTES-1] = bus.i_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            gap_cnt        <= '0;
            wait_low       <= 1'b0;
            cipher_sh      <= '0;
            tag_sh         <= '0;
            bus.o_cipher   <= '0;
            bus.o_tag      <= '0;
            bus.o_done     <= 1'b0;
            bus.o_tag_ok   <= 1'b0;
            bus.o_err      <= 1'b0;
            bus.o_err_code <= '0;
            bus.o_busy     <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            bus.o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (wait_low) begin
                        if (!bus.i_valid) wait_low <= 1'b0;
                    end else if (bus.i_valid) begin
                        cipher_sh[0] <= bus.i_data;
                        cnt          <= 5'd1;
                        state        <= CIPHER;
                        bus.o_busy   <= 1'b1;
                    end
                end
                CIPHER: begin
                    if (bus.i_valid) begin
                        cipher_sh[cnt[3:0]] <= bus.i_data;
                        cnt                 <= cnt + 5'd1;
                        if (cnt == LAST) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end
                    end else begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= 2'd1;
                        state          <= IDLE;
                        bus.o_busy     <= 1'b0;
                    end
                end
                GAP: begin
                    if (bus.i_valid) begin
                        tag_sh[0] <= bus.i_data;
                        cnt       <= 5'd1;
                        state     <= TAG;
                    end else if (gap_cnt == GAP_LAST) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= 2'd2;
                        state          <= IDLE;
                        bus.o_busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                TAG: begin
                    if (bus.i_valid) begin
                        tag_sh[cnt[3:0]] <= bus.i_data;
                        cnt              <= cnt + 5'd1;
                        if (cnt == LAST) begin
                            state        <= DONE;
                            bus.o_done   <= 1'b1;
                            bus.o_cipher <= cipher_sh;
                            bus.o_tag    <= tag_full;
                            bus.o_tag_ok <= bus.i_check_en ? (tag_full == bus.i_exp_tag) : 1'b1;
                        end
                    end else begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= 2'd1;
                        state          <= IDLE;
                        bus.o_busy     <= 1'b0;
                    end
                end
                DONE: begin
                    // A byte here is an overrun. The frame already published
                    // is kept, and this byte is dropped.
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                    if (bus.i_valid) begin
                        bus.o_err      <= 1'b1;
                        bus.o_err_code <= 2'd3;
                        wait_low       <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.o_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule
